// File: rtl/chunk_addsub_pkg.sv
// Shared state encoding and sizing helpers for the chunked adder/subtractor.
package chunk_addsub_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int unsigned nchunk_of(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Chunk index needs at least one bit even when a single chunk covers the word.
  function automatic int unsigned idx_w_of(input int unsigned width, input int unsigned chunk);
    return (width / chunk > 1) ? $clog2(width / chunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_addsub_fadd.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into its MSB for overflow.
module chunk_fadd #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] cy;

  always_comb begin
    cy    = '0;
    sum   = '0;
    cy[0] = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      sum[i]  = a[i] ^ b[i] ^ cy[i];
      cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = cy[CHUNK];
  assign c_msb = cy[CHUNK-1];

endmodule

// File: rtl/chunk_addsub.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock, LSB first, valid/ready on both sides.
module chunk_addsub
  import chunk_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf
);

  localparam int unsigned NCHUNK = nchunk_of(WIDTH, CHUNK);
  localparam int unsigned IDX_W  = idx_w_of(WIDTH, CHUNK);

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] xa, yb;
  logic             cy;
  logic [IDX_W-1:0] k;

  logic [CHUNK-1:0] a_c, b_c, sum_c;
  logic             cout_c, cmsb_c, last_c;
  int unsigned      base_c;

  // Slice selection for the chunk currently being processed.
  always_comb begin
    base_c = 32'(k) * CHUNK;
    a_c    = xa[base_c +: CHUNK];
    b_c    = yb[base_c +: CHUNK];
    last_c = (k == IDX_W'(NCHUNK - 1));
  end

  chunk_fadd #(.CHUNK(CHUNK)) u_fadd (
    .a     (a_c),
    .b     (b_c),
    .cin   (cy),
    .sum   (sum_c),
    .cout  (cout_c),
    .c_msb (cmsb_c)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = RUN;
      RUN:     if (last_c) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand latch, chunk walk and result registers; handshake flags follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      xa        <= '0;
      yb        <= '0;
      cy        <= 1'b0;
      k         <= '0;
      s         <= '0;
      c         <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            xa <= x;
            yb <= sub ? ~y : y;
            cy <= sub;
            k  <= '0;
          end
        end
        RUN: begin
          s[base_c +: CHUNK] <= sum_c;
          cy <= cout_c;
          k  <= k + IDX_W'(1);
          if (last_c) begin
            c   <= cout_c;
            ovf <= cmsb_c ^ cout_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_addsub.sv
// Bench for chunk_addsub in three configurations against an arithmetic reference model.
module tb_chunk_addsub;

  logic clk;
  logic rst_n;

  logic [2:0]  iv, ordy, sb, ir, ov, co, ofl;
  logic [15:0] xs [3];
  logic [15:0] ys [3];
  logic [7:0]  s0, s1;
  logic [15:0] s2;

  int vectors;
  int miscompares;

  logic [15:0] exp_s;
  logic        exp_c, exp_o;

  chunk_addsub #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .x(xs[0][7:0]), .y(ys[0][7:0]), .sub(sb[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .s(s0), .c(co[0]), .ovf(ofl[0]));

  chunk_addsub #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .x(xs[1][7:0]), .y(ys[1][7:0]), .sub(sb[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .s(s1), .c(co[1]), .ovf(ofl[1]));

  chunk_addsub #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .x(xs[2]), .y(ys[2]), .sub(sb[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .s(s2), .c(co[2]), .ovf(ofl[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned width_of(input int sel);
    return (sel == 2) ? 16 : 8;
  endfunction

  function automatic int unsigned lat_of(input int sel);
    case (sel)
      0:       return 4;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [15:0] get_s(input int sel);
    case (sel)
      0:       return {8'h00, s0};
      1:       return {8'h00, s1};
      default: return s2;
    endcase
  endfunction

  // Reference: unsigned result/carry from integer arithmetic, ovf from the true signed result.
  task automatic model(input int sel, input logic [15:0] xv, input logic [15:0] yv, input logic subv);
    int unsigned w, m, xa, ya, tot;
    int          xsg, ysg, res, lo, hi;
    w   = width_of(sel);
    m   = (32'd1 << w) - 1;
    xa  = 32'(xv) & m;
    ya  = 32'(yv) & m;
    xsg = (xa >= (m + 1) / 2) ? int'(xa) - int'(m + 1) : int'(xa);
    ysg = (ya >= (m + 1) / 2) ? int'(ya) - int'(m + 1) : int'(ya);
    lo  = -int'((m + 1) / 2);
    hi  = int'((m + 1) / 2) - 1;
    if (subv) begin
      tot   = (xa - ya) & m;
      exp_c = (xa >= ya);
      res   = xsg - ysg;
    end else begin
      tot   = xa + ya;
      exp_c = (tot > m);
      tot   = tot & m;
      res   = xsg + ysg;
    end
    exp_s = 16'(tot);
    exp_o = (res < lo) || (res > hi);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents operands in IDLE; returns #1 after the accept edge with operands scrambled.
  task automatic issue(input int sel, input logic [15:0] xv, input logic [15:0] yv, input logic subv);
    chk("ready_before_accept", 32'(ir[sel]), 32'd1);
    iv[sel] = 1'b1;
    xs[sel] = xv;
    ys[sel] = yv;
    sb[sel] = subv;
    @(posedge clk);
    #1;
    iv[sel] = 1'b0;
    xs[sel] = 16'($urandom);
    ys[sel] = 16'($urandom);
    sb[sel] = 1'($urandom);
    chk("ready_low_in_run", 32'(ir[sel]), 32'd0);
  endtask

  task automatic wait_result(input int sel, input logic [15:0] xv, input logic [15:0] yv, input logic subv);
    int lat;
    lat = 0;
    model(sel, xv, yv, subv);
    while (!ov[sel] && lat < 64) begin
      chk("ready_low_while_busy", 32'(ir[sel]), 32'd0);
      @(posedge clk);
      #1;
      xs[sel] = 16'($urandom);
      lat++;
    end
    chk("latency", 32'(lat), 32'(lat_of(sel)));
    chk("s", 32'(get_s(sel)), 32'(exp_s));
    chk("c", 32'(co[sel]), 32'(exp_c));
    chk("ovf", 32'(ofl[sel]), 32'(exp_o));
  endtask

  // Holds DONE for 'hold' cycles, optionally with a pending request, then hands off.
  task automatic release_res(input int sel, input int hold, input bit pv,
                             input logic [15:0] x2, input logic [15:0] y2, input logic sub2);
    ordy[sel] = 1'b0;
    if (pv) begin
      iv[sel] = 1'b1;
      xs[sel] = x2;
      ys[sel] = y2;
      sb[sel] = sub2;
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(ov[sel]), 32'd1);
      chk("hold_ready", 32'(ir[sel]), 32'd0);
      chk("hold_s", 32'(get_s(sel)), 32'(exp_s));
      chk("hold_c", 32'(co[sel]), 32'(exp_c));
      chk("hold_ovf", 32'(ofl[sel]), 32'(exp_o));
    end
    ordy[sel] = 1'b1;
    @(posedge clk);
    #1;
    ordy[sel] = 1'b0;
    chk("idle_valid", 32'(ov[sel]), 32'd0);
    chk("idle_ready", 32'(ir[sel]), 32'd1);
    chk("idle_s_kept", 32'(get_s(sel)), 32'(exp_s));
    chk("idle_c_kept", 32'(co[sel]), 32'(exp_c));
    if (pv) begin
      @(posedge clk);
      #1;
      iv[sel] = 1'b0;
      chk("accept_after_handshake", 32'(ir[sel]), 32'd0);
      wait_result(sel, x2, y2, sub2);
      release_res(sel, 0, 1'b0, 16'h0, 16'h0, 1'b0);
    end
  endtask

  task automatic op(input int sel, input logic [15:0] xv, input logic [15:0] yv, input logic subv, input int hold);
    issue(sel, xv, yv, subv);
    wait_result(sel, xv, yv, subv);
    release_res(sel, hold, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    iv          = '0;
    ordy        = '0;
    sb          = '0;
    for (int i = 0; i < 3; i++) begin
      xs[i] = '0;
      ys[i] = '0;
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", 32'(ir[i]), 32'd1);
      chk("rst_valid", 32'(ov[i]), 32'd0);
      chk("rst_s", 32'(get_s(i)), 32'd0);
      chk("rst_c", 32'(co[i]), 32'd0);
      chk("rst_ovf", 32'(ofl[i]), 32'd0);
    end
    rst_n = 1'b1;

    // Directed add/subtract cases on the default configuration.
    op(0, 16'h1F, 16'h2A, 1'b0, 0);
    op(0, 16'hFF, 16'hFF, 1'b0, 1);
    op(0, 16'h7F, 16'h01, 1'b0, 0);
    op(0, 16'h05, 16'h07, 1'b1, 0);
    op(0, 16'h80, 16'h01, 1'b1, 0);

    // Backpressure with a request waiting during DONE.
    issue(0, 16'h33, 16'h44, 1'b0);
    wait_result(0, 16'h33, 16'h44, 1'b0);
    release_res(0, 5, 1'b1, 16'h10, 16'h20, 1'b1);

    // Reset in the middle of RUN.
    issue(0, 16'hAB, 16'hCD, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_s", 32'(get_s(0)), 32'd0);
    chk("midrun_rst_c", 32'(co[0]), 32'd0);
    chk("midrun_rst_ovf", 32'(ofl[0]), 32'd0);
    chk("midrun_rst_ready", 32'(ir[0]), 32'd1);
    chk("midrun_rst_valid", 32'(ov[0]), 32'd0);
    #1;
    rst_n = 1'b1;
    op(0, 16'h01, 16'h01, 1'b0, 0);

    // Other configurations.
    op(1, 16'h1F, 16'h2A, 1'b0, 0);
    op(1, 16'h05, 16'h07, 1'b1, 2);
    op(2, 16'hFFFF, 16'h0001, 1'b0, 0);
    op(2, 16'h8000, 16'h0001, 1'b1, 1);

    // Random sweep across all configurations.
    for (int sel = 0; sel < 3; sel++) begin
      for (int n = 0; n < 15; n++) begin
        op(sel, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chunk_addsub.md
CHUNK_ADDSUB -- requirements
Module: chunk_addsub

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; legal values are 2 or more.
REQ-002 Parameter CHUNK, default 2: bits added per clock cycle; WIDTH % CHUNK == 0 is mandatory, and CHUNK == WIDTH is legal.
REQ-003 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-004 Ports SHALL be, in order:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and mode present.
- in_ready  out  1  block can accept operands.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- sub  in  1  mode select: 0 = x+y, 1 = x-y.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- s  out  WIDTH  sum or difference.
- c  out  1  carry-out (for sub, 1 = no borrow).
- ovf  out  1  two's-complement overflow.

Function
REQ-005 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-006 In IDLE, in_ready=1 and out_valid=0.
REQ-007 On an edge with in_valid&&in_ready, the block SHALL:
- latch x;
- latch y if sub=0, or ~y if sub=1;
- set the carry register to sub;
- clear the chunk index;
- go to RUN.
REQ-008 In RUN, each edge SHALL add chunk k of both latched operands plus the carry register, write the CHUNK result bits to s[k*CHUNK +: CHUNK], update the carry register, and increment k.
REQ-009 Chunk 0 holds the LSBs, and processing SHALL run from LSB to MSB.
REQ-010 On the edge that processes chunk NCHUNK-1 (NCHUNK = WIDTH/CHUNK), the block SHALL go to DONE.
REQ-011 On that same edge, c SHALL take the final carry and ovf SHALL take (carry into bit WIDTH-1) XOR (final carry).
REQ-012 Latency: out_valid SHALL rise exactly NCHUNK cycles after the accept edge; for the defaults this is 4 cycles.
REQ-013 In DONE, out_valid=1, in_ready=0, and s, c and ovf SHALL be held stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-014 in_ready SHALL be 0 in RUN and DONE. x, y, sub and in_valid SHALL be ignored in those states, and operand changes during RUN SHALL NOT affect the result.
REQ-015 out_ready SHALL be ignored outside DONE.
REQ-016 Back-to-back operation: the earliest next accept SHALL be on the edge after the DONE→IDLE edge. An in_valid asserted in DONE SHALL NOT be accepted in the same cycle.
REQ-017 s, c and ovf SHALL retain the last result through IDLE until the next accept.
REQ-018 Arithmetic SHALL be modulo 2^WIDTH, and all values SHALL be unsigned bit vectors; signedness is applied only in the ovf interpretation.

Reset
REQ-019 When rst_n=0, the block SHALL immediately force:
- state = IDLE;
- in_ready = 1;
- out_valid = 0;
- s = 0, c = 0, ovf = 0;
- latched operands, carry register and chunk index = 0.
REQ-020 Reset asserted during RUN or DONE SHALL abort the operation, and the result SHALL be discarded.
REQ-021 After rst_n deasserts, the first rising edge SHALL be able to accept operands.

Structure
REQ-022 Package chunk_addsub_pkg SHALL contain the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the NCHUNK/index-width helper function.
REQ-023 A sub-module chunk_fadd (CHUNK-bit combinational ripple adder) SHALL provide sum, carry-out, and the carry into the chunk MSB.
REQ-024 chunk_fadd SHALL be instantiated once and time-shared across chunks.
REQ-025 No other hierarchy SHALL be used.

Verification (WIDTH=8, CHUNK=2 unless stated)
REQ-026 Add: x=0x1F, y=0x2A, sub=0 -> after 4 cycles, s=0x49, c=0, ovf=0.
REQ-027 Add with wrap: x=0xFF, y=0xFF -> s=0xFE, c=1, ovf=0. Signed overflow: x=0x7F, y=0x01 -> s=0x80, c=0, ovf=1.
REQ-028 Subtract with borrow: x=0x05, y=0x07, sub=1 -> s=0xFE, c=0, ovf=0. No borrow: x=0x80, y=0x01, sub=1 -> s=0x7F, c=1, ovf=1.
REQ-029 Backpressure: out_ready is held at 0 for 5 cycles in DONE -> s, c, ovf and out_valid are stable and in_ready=0 throughout; an accept occurs on the edge after the out_ready handshake.
REQ-030 Reset mid-RUN: rst_n is pulsed low after 2 RUN cycles -> outputs are zero immediately and in_ready=1; a new operation 0x01+0x01 then gives s=0x02.
REQ-031 Parameter sweep: WIDTH=8/CHUNK=8 gives 1-cycle latency; WIDTH=16/CHUNK=4 with x=0xFFFF, y=0x0001 gives s=0x0000, c=1; a random compare against a reference model passes in all configurations.
